// File: rtl/noc_from_arb.sv
// noc_from_arb: merges NDEV noc_from_dev byte streams onto one upstream port, whole packets at a time
// Ports: clk; reset (async, active-low); dev_ctl/dev_data per-port inputs (port i on dev_data[8i+7:8i]);
//        noc_ctl/noc_data registered merged output; overflow sticky per-port packet-dropped flags.
// Define FROM_ARB_PRIO_EN for fixed lowest-index priority instead of round-robin.
module noc_from_arb #(
  parameter int NDEV  = 2,
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NDEV-1:0]   dev_ctl,
  input  logic [8*NDEV-1:0] dev_data,
  output logic              noc_ctl,
  output logic [7:0]        noc_data,
  output logic [NDEV-1:0]   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int GW = $clog2(NDEV);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  logic [NDEV-1:0] pending, pop;
  logic [9:0] dout [NDEV];
  state_t st_q, st_d;
  logic [GW-1:0] gnt_q, gnt_d, rr_q, rr_d, sel, idx;
  logic noc_ctl_q, noc_ctl_d;
  logic [7:0] noc_data_q, noc_data_d;
  for (genvar i = 0; i < NDEV; i++) begin : g_port
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, pstart_q, pstart_d, cnt_q, cnt_d;
    logic stg_v_q, stg_v_d, ovf_q, ovf_d, full, we, hit, c;
    logic [7:0] d;
    logic [8:0] stg_q, stg_d;
    logic [9:0] mem_q [DEPTH];
    always_comb begin
      c = dev_ctl[i];
      d = dev_data[8*i +: 8];
      full = wptr_q[AW] != rptr_q[AW] && wptr_q[AW-1:0] == rptr_q[AW-1:0];
      we = stg_v_q && !full;
      hit = stg_v_q && full;
      wptr_d = hit ? (stg_q[8] ? wptr_q : pstart_q) : wptr_q + PW'(we);
      pstart_d = we && stg_q[8] ? wptr_q : pstart_q;
      stg_v_d = c ? d != 8'd0 : stg_v_q && !hit;
      stg_d = {c, d};
      ovf_d = ovf_q || hit;
      rptr_d = rptr_q + PW'(pop[i]);
      cnt_d = cnt_q + PW'(we && c) - PW'(pop[i] && dout[i][9]);
    end
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        wptr_q <= '0;
        rptr_q <= '0;
        pstart_q <= '0;
        cnt_q <= '0;
        stg_v_q <= 1'b0;
        stg_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        pstart_q <= pstart_d;
        cnt_q <= cnt_d;
        stg_v_q <= stg_v_d;
        stg_q <= stg_d;
        ovf_q <= ovf_d;
      end
    always_ff @(posedge clk)
      if (we) mem_q[wptr_q[AW-1:0]] <= {c, stg_q};
    assign dout[i] = mem_q[rptr_q[AW-1:0]];
    assign pending[i] = cnt_q != '0;
    assign overflow[i] = ovf_q;
  end
  always_comb begin
    sel = rr_q;
    idx = '0;
    for (int k = NDEV - 1; k >= 0; k--) begin
`ifdef FROM_ARB_PRIO_EN
      idx = GW'(k);
`else
      idx = GW'((int'(rr_q) + k) % NDEV);
`endif
      sel = pending[idx] ? idx : sel;
    end
    st_d = st_q;
    gnt_d = gnt_q;
    rr_d = rr_q;
    noc_ctl_d = 1'b1;
    noc_data_d = 8'd0;
    pop = '0;
    if (st_q == IDLE && pending != '0) begin
      st_d = SEND;
      gnt_d = sel;
    end
    if (st_q == SEND) begin
      pop[gnt_q] = 1'b1;
      {noc_ctl_d, noc_data_d} = dout[gnt_q][8:0];
      if (dout[gnt_q][9]) begin
        st_d = GAP;
        rr_d = gnt_q == GW'(NDEV - 1) ? '0 : gnt_q + 1'b1;
      end
    end
    if (st_q == GAP) st_d = IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st_q <= IDLE;
      gnt_q <= '0;
      rr_q <= '0;
      noc_ctl_q <= 1'b1;
      noc_data_q <= 8'd0;
    end else begin
      st_q <= st_d;
      gnt_q <= gnt_d;
      rr_q <= rr_d;
      noc_ctl_q <= noc_ctl_d;
      noc_data_q <= noc_data_d;
    end
  assign noc_ctl = noc_ctl_q;
  assign noc_data = noc_data_q;
endmodule

// File: tb/tb_noc_from_arb.sv
// tb_noc_from_arb: scoreboard bench for noc_from_arb with NDEV=2, DEPTH=16
module tb_noc_from_arb;
  typedef struct packed {int unsigned cyc; logic [8:0] b;} obs_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] dev_ctl = 2'b11;
  logic [15:0] dev_data = 16'h0;
  logic noc_ctl;
  logic [7:0] noc_data;
  logic [1:0] overflow;
  int unsigned cyc = 0;
  int pass_n = 0;
  int chk_n = 0;
  logic [8:0] exp0[$];
  logic [8:0] exp1[$];
  obs_t obs[$];

  noc_from_arb #(.NDEV(2), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .dev_ctl(dev_ctl), .dev_data(dev_data),
    .noc_ctl(noc_ctl), .noc_data(noc_data), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (reset && !(noc_ctl && noc_data == 8'h00)) obs.push_back({cyc, noc_ctl, noc_data});

  task automatic drive(input logic [1:0] fw, input logic c0, input logic [7:0] d0,
                       input logic c1, input logic [7:0] d1);
    dev_ctl = {c1, c0};
    dev_data = {d1, d0};
    if (fw[0]) exp0.push_back({c0, d0});
    if (fw[1]) exp1.push_back({c1, d1});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(2'b00, 1'b1, 8'h00, 1'b1, 8'h00);
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    chk_n++;
    if (noc_ctl !== 1'b1) $display("FAIL reset_ctl: got %b want 1", noc_ctl); else pass_n++;
    chk_n++;
    if (noc_data !== 8'h00) $display("FAIL reset_data: got %h want 00", noc_data); else pass_n++;
    chk_n++;
    if (overflow !== 2'b00) $display("FAIL reset_overflow: got %b want 00", overflow); else pass_n++;
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_single;
    int unsigned t;
    logic [8:0] e;
    drive(2'b01, 1'b1, 8'h23, 1'b1, 8'h00);
    drive(2'b01, 1'b0, 8'h11, 1'b1, 8'h00);
    drive(2'b01, 1'b0, 8'h22, 1'b1, 8'h00);
    t = cyc;
    idle(10);
    chk_n++;
    if (obs.size() != 3) $display("FAIL single_count: got %0d want 3", obs.size());
    else begin
      pass_n++;
      chk_n++;
      if (obs[0].cyc !== t + 3) $display("FAIL single_latency: got %0d want %0d", obs[0].cyc - t, 3); else pass_n++;
      chk_n++;
      if (obs[2].cyc !== obs[0].cyc + 2) $display("FAIL single_contig: got %0d want %0d", obs[2].cyc, obs[0].cyc + 2); else pass_n++;
      for (int k = 0; k < 3; k++) begin
        e = exp0.pop_front();
        chk_n++;
        if (obs[k].b !== e) $display("FAIL single_byte%0d: got %h want %h", k, obs[k].b, e); else pass_n++;
      end
    end
    obs.delete(); exp0.delete(); exp1.delete();
  endtask

  task automatic test_b2b;
    logic [8:0] e;
    drive(2'b10, 1'b1, 8'h00, 1'b1, 8'h31);
    drive(2'b10, 1'b1, 8'h00, 1'b0, 8'hAA);
    drive(2'b10, 1'b1, 8'h00, 1'b1, 8'h32);
    drive(2'b10, 1'b1, 8'h00, 1'b0, 8'hBB);
    drive(2'b00, 1'b1, 8'h00, 1'b1, 8'h00);
    chk_n++;
    if (dut.g_port[1].cnt_q !== 5'd2) $display("FAIL b2b_pkt_cnt: got %0d want 2", dut.g_port[1].cnt_q); else pass_n++;
    idle(14);
    chk_n++;
    if (obs.size() != 4) $display("FAIL b2b_count: got %0d want 4", obs.size());
    else begin
      pass_n++;
      chk_n++;
      if (obs[2].cyc !== obs[1].cyc + 3) $display("FAIL b2b_gap: got %0d want 3", obs[2].cyc - obs[1].cyc); else pass_n++;
      for (int k = 0; k < 4; k++) begin
        e = exp1.pop_front();
        chk_n++;
        if (obs[k].b !== e) $display("FAIL b2b_byte%0d: got %h want %h", k, obs[k].b, e); else pass_n++;
      end
    end
    obs.delete(); exp0.delete(); exp1.delete();
  endtask

  task automatic test_simul;
    logic [8:0] e;
    drive(2'b11, 1'b1, 8'h51, 1'b1, 8'h61);
    drive(2'b11, 1'b0, 8'h52, 1'b0, 8'h62);
    drive(2'b11, 1'b0, 8'h53, 1'b0, 8'h63);
    idle(16);
    chk_n++;
    if (obs.size() != 6) $display("FAIL simul_count: got %0d want 6", obs.size());
    else begin
      pass_n++;
      chk_n++;
      if (obs[3].cyc !== obs[2].cyc + 3) $display("FAIL simul_gap: got %0d want 3", obs[3].cyc - obs[2].cyc); else pass_n++;
      for (int k = 0; k < 6; k++) begin
        e = k < 3 ? exp0.pop_front() : exp1.pop_front();
        chk_n++;
        if (obs[k].b !== e) $display("FAIL simul_byte%0d: got %h want %h", k, obs[k].b, e); else pass_n++;
      end
    end
    chk_n++;
    if (dut.rr_q !== 1'b0) $display("FAIL simul_rr: got %0d want 0", dut.rr_q); else pass_n++;
    obs.delete(); exp0.delete(); exp1.delete();
  endtask

  task automatic test_order;
    int ord[4];
    logic [8:0] e;
`ifdef FROM_ARB_PRIO_EN
    ord = '{0, 0, 1, 1};
`else
    ord = '{0, 1, 0, 1};
`endif
    drive(2'b11, 1'b1, 8'h90, 1'b1, 8'h81);
    drive(2'b11, 1'b1, 8'h91, 1'b1, 8'h82);
    idle(24);
    chk_n++;
    if (obs.size() != 4) $display("FAIL order_count: got %0d want 4", obs.size());
    else begin
      pass_n++;
      for (int k = 0; k < 4; k++) begin
        e = ord[k] == 1 ? exp1.pop_front() : exp0.pop_front();
        chk_n++;
        if (obs[k].b !== e) $display("FAIL order_byte%0d: got %h want %h", k, obs[k].b, e); else pass_n++;
      end
    end
    obs.delete(); exp0.delete(); exp1.delete();
  endtask

  task automatic test_overflow;
    logic [8:0] e;
    drive(2'b00, 1'b1, 8'h70, 1'b1, 8'h00);
    for (int k = 0; k < 20; k++) drive(2'b00, 1'b0, 8'(k + 1), 1'b1, 8'h00);
    idle(1);
    chk_n++;
    if (overflow !== 2'b01) $display("FAIL ovf_flag: got %b want 01", overflow); else pass_n++;
    drive(2'b01, 1'b1, 8'h40, 1'b1, 8'h00);
    drive(2'b01, 1'b0, 8'h41, 1'b1, 8'h00);
    idle(12);
    chk_n++;
    if (overflow !== 2'b01) $display("FAIL ovf_sticky: got %b want 01", overflow); else pass_n++;
    chk_n++;
    if (obs.size() != 2) $display("FAIL ovf_count: got %0d want 2", obs.size());
    else begin
      pass_n++;
      for (int k = 0; k < 2; k++) begin
        e = exp0.pop_front();
        chk_n++;
        if (obs[k].b !== e) $display("FAIL ovf_byte%0d: got %h want %h", k, obs[k].b, e); else pass_n++;
      end
    end
    obs.delete(); exp0.delete(); exp1.delete();
  endtask

  task automatic test_reset_mid;
    logic seen = 1'b0;
    drive(2'b00, 1'b1, 8'h55, 1'b1, 8'h00);
    drive(2'b00, 1'b0, 8'h66, 1'b1, 8'h00);
    drive(2'b00, 1'b0, 8'h77, 1'b1, 8'h00);
    drive(2'b00, 1'b1, 8'h00, 1'b1, 8'h00);
    for (int k = 0; k < 20 && !seen; k++) begin
      seen = noc_ctl === 1'b1 && noc_data === 8'h55;
      if (!seen) @(negedge clk);
    end
    chk_n++;
    if (!seen) $display("FAIL rmid_first: got timeout want 155");
    else begin
      pass_n++;
      @(negedge clk);
      chk_n++;
      if ({noc_ctl, noc_data} !== 9'h066) $display("FAIL rmid_second: got %h want 066", {noc_ctl, noc_data}); else pass_n++;
    end
    reset = 1'b0;
    #1;
    chk_n++;
    if (noc_ctl !== 1'b1) $display("FAIL rmid_ctl: got %b want 1", noc_ctl); else pass_n++;
    chk_n++;
    if (noc_data !== 8'h00) $display("FAIL rmid_data: got %h want 00", noc_data); else pass_n++;
    chk_n++;
    if (overflow !== 2'b00) $display("FAIL rmid_overflow: got %b want 00", overflow); else pass_n++;
    @(negedge clk);
    reset = 1'b1;
    obs.delete();
    idle(12);
    chk_n++;
    if (obs.size() != 0) $display("FAIL rmid_empty: got %0d bytes want 0", obs.size()); else pass_n++;
    obs.delete(); exp0.delete(); exp1.delete();
  endtask

  initial begin
    test_reset;
    test_single;
    test_b2b;
    test_simul;
    test_order;
    test_overflow;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end
endmodule

// File: doc/noc_from_arb.md
Name: noc_from_arb

Overview:
- Return-path arbiter for the NOC switch. Merges the noc_from_dev byte streams of NDEV attached devices onto the single upstream noc_from_dev interface.
- Each device output cannot be stalled, so every port owns a byte FIFO. Only complete packets are buffered for forwarding.
- Whole packets are granted round-robin, so packets are never interleaved upstream.

Parameters:
- NDEV, 2, number of device return ports (2..8).
- DEPTH, 16, FIFO entries per port; power of 2; also the maximum forwardable packet length in bytes.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- dev_ctl  input  NDEV  per-port noc_from_dev_ctl.
- dev_data  input  8*NDEV  per-port noc_from_dev_data; port i uses bits [8i+7:8i].
- noc_ctl  output  1  merged noc_from_dev_ctl, registered.
- noc_data  output  8  merged noc_from_dev_data, registered.
- overflow  output  NDEV  sticky per-port packet-dropped flag.

Behaviour:
- Byte classes:
  - NOP: ctl=1, data=0.
  - Command: ctl=1, data≠0.
  - Payload: ctl=0.
- Packet = one command byte plus zero or more payload bytes. It is terminated by the next ctl=1 byte (NOP or command).
- Payload received outside a packet is discarded silently.
- Reset (asynchronous, active-low): noc_ctl=1, noc_data=0, overflow=0, all FIFOs empty, pkt_cnt=0, staging invalid, arbiter in IDLE, rr pointer=0.
- Ingress, per port, every cycle:
  - A non-NOP in-packet byte is loaded into the staging register.
  - The previous staged byte is written to the FIFO as {eop,ctl,data}. eop=1 when the current input byte is ctl=1.
  - On a terminator, staging is flushed with eop=1 and pkt_cnt increments in the same cycle.
  - A command byte immediately after a packet both terminates the old packet and starts the new one.
  - pkt_start_ptr latches the write pointer when each command byte is written.
- Overflow, per port:
  - Trigger: a write is required while the FIFO is full.
  - Write pointer rolls back to pkt_start_ptr, discarding the partial packet. overflow[i] sets and stays set until reset.
  - The port enters DISCARD and drops bytes until the next command byte, which starts a fresh packet normally.
  - Complete packets already in the FIFO are untouched. A packet longer than DEPTH is always discarded.
- Arbiter states:
  - IDLE: drive NOP. If any pkt_cnt>0, grant the first requesting port at or after rr pointer (wrapping) and go to SEND. Otherwise stay in IDLE.
  - SEND: pop one entry per cycle from the granted port and register it onto noc_ctl/noc_data. On popping an eop entry, decrement that port's pkt_cnt, set rr pointer = grant+1 (mod NDEV), and go to GAP.
  - GAP: drive one NOP, then go to IDLE.
- The arbiter is the only reader and pops only complete packets, so no underflow is possible.
- Simultaneous pkt_cnt increment (ingress) and decrement (arbiter) on one port in one cycle: net zero.
- Latency: first output byte appears 3 cycles after the terminator byte is sampled (pkt_cnt update, grant, output register).
- Throughput: back-to-back packets from the arbiter are separated by at least 2 NOP cycles (GAP + IDLE).
- FIFO pointers are log2(DEPTH)+1 bits; full/empty are decided by MSB compare; wrap-around is natural modulo.

Optional Feature:
- Macro: FROM_ARB_PRIO_EN.
- Defined: IDLE uses fixed priority, lowest-index requesting port wins, and the rr pointer is unused.
- Undefined: round-robin as specified in Behaviour.

Test Plan:
- Single packet: port0 sends cmd 0x23 + 2 payload bytes (0x11, 0x22), then NOP. Required output, starting 3 cycles after the NOP: ctl/data (1,0x23), (0,0x11), (0,0x22), then NOP.
- Simultaneous completion: port0 and port1 each complete a 3-byte packet in the same cycle, rr=0. Required: port0 packet, 2 NOPs, port1 packet; rr ends at 0.
- Back-to-back commands: port1 sends cmd 0x31, pay 0xAA, cmd 0x32, pay 0xBB, NOP. Required: two separate packets, each with eop on its payload byte; pkt_cnt reaches 2.
- Overflow: DEPTH=16, port0 sends cmd + 20 payload bytes. Required: overflow[0]=1, no output from that packet. A following cmd 0x40 + 1 byte packet is forwarded intact.
- Reset mid-SEND: assert reset during the 2nd byte of a packet. Required: noc_ctl=1, noc_data=0 immediately; FIFOs empty; overflow=0.
- With FROM_ARB_PRIO_EN: port1 has pending packets continuously and port0 completes one. Required: port0 is granted at the next IDLE.
